// File: rtl/mips_step_ctrl_if.sv
// mips_step_ctrl_if: board-side control and status bundle for the MIPS
// execution sequencer.
//   master : board/debug side; drives step/run/burst requests, the
//            breakpoint setup and the SoC PC, and observes the status.
//   slave  : the sequencer; consumes requests, produces cpu_en and status.
// Signals:
//   step_btn, run_sw, burst_req, burst_len[BURST_W] : execution requests
//   brk_en, brk_pc[32], pc_current[32]              : breakpoint compare
//   cpu_en, halted, brk_hit, state[2], instr_cnt[32]: sequencer outputs
interface mips_step_ctrl_if #(
    parameter int BURST_W = 8
);
    logic               step_btn;
    logic               run_sw;
    logic               burst_req;
    logic [BURST_W-1:0] burst_len;
    logic               brk_en;
    logic [31:0]        brk_pc;
    logic [31:0]        pc_current;
    logic               cpu_en;
    logic               halted;
    logic               brk_hit;
    logic [1:0]         state;
    logic [31:0]        instr_cnt;

    modport master (
        output step_btn, run_sw, burst_req, burst_len, brk_en, brk_pc, pc_current,
        input  cpu_en, halted, brk_hit, state, instr_cnt
    );

    modport slave (
        input  step_btn, run_sw, burst_req, burst_len, brk_en, brk_pc, pc_current,
        output cpu_en, halted, brk_hit, state, instr_cnt
    );
endinterface

// File: rtl/mips_step_ctrl.sv
// mips_step_ctrl: execution sequencer for the board-level MIPS SoC.
// Produces a single-cycle clock enable (cpu_en) that advances the core one
// instruction at a time: single-step on a button edge, free-run every
// RUN_DIV cycles, or a fixed-length burst, with a PC breakpoint that stops
// free-run and burst execution.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   bus  : mips_step_ctrl_if.slave (requests in, cpu_en/status out)
//
// state  | meaning
// HALT   | idle; step edges issue single pulses; run/burst start here
// RUN    | free-run, one pulse per RUN_DIV cycles while run_sw=1
// BURST  | pulse per RUN_DIV cycles until the burst count is used up
// BREAK  | stopped on breakpoint; a step edge steps off and returns to HALT
module mips_step_ctrl #(
    parameter int RUN_DIV = 20000,
    parameter int BURST_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mips_step_ctrl_if.slave  bus
);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_BURST = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic               cpu_en_q, cpu_en_d;
    logic               brk_hit_q, brk_hit_d;
    logic [31:0]        instr_cnt_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               btn_q;

    logic step_edge;
    logic fire;
    logic match;

    assign step_edge = bus.step_btn & ~btn_q;
    assign fire      = (div_q == DIV_LAST);
    assign match     = bus.brk_en & (bus.pc_current == bus.brk_pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HALT;
            cpu_en_q    <= 1'b0;
            brk_hit_q   <= 1'b0;
            instr_cnt_q <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            // Starts high so a button held through reset release is not a step.
            btn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            brk_hit_q   <= brk_hit_d;
            instr_cnt_q <= instr_cnt_q + 32'(cpu_en_q);
            div_q       <= div_d;
            rem_q       <= rem_d;
            btn_q       <= bus.step_btn;
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_en_d  = 1'b0;
        brk_hit_d = brk_hit_q;
        rem_d     = rem_q;
        // Divider only runs in RUN/BURST; every other path leaves it at 0,
        // which also gives a clean 0 on entry to RUN/BURST.
        div_d     = '0;

        unique case (state_q)
            S_HALT: begin
                if (bus.run_sw) begin
                    state_d = S_RUN;
                end else if (bus.burst_req && (bus.burst_len != '0)) begin
                    state_d = S_BURST;
                    rem_d   = bus.burst_len;
                end else if (step_edge) begin
                    cpu_en_d = 1'b1;
                end
            end

            S_RUN: begin
                // Dropping run_sw wins over a coincident fire.
                if (!bus.run_sw) begin
                    state_d = S_HALT;
                end else if (fire) begin
                    if (match) begin
                        state_d   = S_BREAK;
                        brk_hit_d = 1'b1;
                    end else begin
                        cpu_en_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_BURST: begin
                if (fire) begin
                    if (match) begin
                        state_d   = S_BREAK;
                        brk_hit_d = 1'b1;
                        rem_d     = '0;
                    end else begin
                        cpu_en_d = 1'b1;
                        rem_d    = rem_q - BURST_W'(1);
                        if (rem_q == BURST_W'(1)) begin
                            state_d = S_HALT;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_BREAK: begin
                if (step_edge) begin
                    cpu_en_d  = 1'b1;
                    brk_hit_d = 1'b0;
                    state_d   = S_HALT;
                end
            end

            default: state_d = S_HALT;
        endcase
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.halted    = (state_q == S_HALT) || (state_q == S_BREAK);
    assign bus.brk_hit   = brk_hit_q;
    assign bus.state     = state_q;
    assign bus.instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_mips_step_ctrl.sv
module tb_mips_step_ctrl;
    localparam int RUN_DIV = 4;
    localparam int BURST_W = 8;

    logic        clk;
    logic        rst;
    logic [31:0] pc;

    int n_checks;
    int n_fail;
    int cyc;
    int pulses;

    mips_step_ctrl_if #(.BURST_W(BURST_W)) bus ();

    mips_step_ctrl #(.RUN_DIV(RUN_DIV), .BURST_W(BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.pc_current = pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: mode numbers follow the published state codes;
    // the rate is tracked as cycles remaining until the next pulse slot.
    int          m_mode;
    int          m_wait;
    int          m_left;
    bit          m_brk;
    bit          m_en;
    bit          m_prev_btn;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_mode     = 0;
        m_wait     = RUN_DIV;
        m_left     = 0;
        m_brk      = 0;
        m_en       = 0;
        m_prev_btn = 1;
        m_cnt      = '0;
    endtask

    task automatic model_step();
        bit edge_seen;
        bit hit;
        bit nx;
        edge_seen  = bus.step_btn && !m_prev_btn;
        hit        = bus.brk_en && (pc == bus.brk_pc);
        nx         = 0;
        m_prev_btn = bus.step_btn;
        if (m_en) m_cnt = m_cnt + 1;
        case (m_mode)
            0: begin
                if (bus.run_sw) begin
                    m_mode = 1; m_wait = RUN_DIV;
                end else if (bus.burst_req && bus.burst_len != 0) begin
                    m_mode = 2; m_wait = RUN_DIV; m_left = int'(bus.burst_len);
                end else if (edge_seen) begin
                    nx = 1;
                end
            end
            1: begin
                if (!bus.run_sw) begin
                    m_mode = 0;
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_wait = RUN_DIV;
                        if (hit) begin m_mode = 3; m_brk = 1; end
                        else nx = 1;
                    end
                end
            end
            2: begin
                m_wait--;
                if (m_wait == 0) begin
                    m_wait = RUN_DIV;
                    if (hit) begin
                        m_mode = 3; m_brk = 1; m_left = 0;
                    end else begin
                        nx = 1;
                        m_left--;
                        if (m_left == 0) m_mode = 0;
                    end
                end
            end
            default: begin
                if (edge_seen) begin
                    nx = 1; m_brk = 0; m_mode = 0;
                end
            end
        endcase
        m_en = nx;
    endtask

    // One system clock: model advances on the pre-edge inputs, the PC moves
    // on the edge that consumes a pulse, outputs are compared 1ns later.
    task automatic tick();
        bit en_before;
        bit exp_halt;
        en_before = m_en;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (en_before) pc = pc + 32'd4;
        if (bus.cpu_en) pulses++;
        exp_halt = (m_mode == 0) || (m_mode == 3);
        n_checks += 5;
        if (bus.cpu_en !== m_en) begin
            n_fail++; $display("FAIL cpu_en cyc %0d got %0b exp %0b", cyc, bus.cpu_en, m_en);
        end
        if (bus.state !== 2'(m_mode)) begin
            n_fail++; $display("FAIL state cyc %0d got %0d exp %0d", cyc, bus.state, m_mode);
        end
        if (bus.brk_hit !== m_brk) begin
            n_fail++; $display("FAIL brk_hit cyc %0d got %0b exp %0b", cyc, bus.brk_hit, m_brk);
        end
        if (bus.instr_cnt !== m_cnt) begin
            n_fail++; $display("FAIL instr_cnt cyc %0d got %0d exp %0d", cyc, bus.instr_cnt, m_cnt);
        end
        if (bus.halted !== exp_halt) begin
            n_fail++; $display("FAIL halted cyc %0d got %0b exp %0b", cyc, bus.halted, exp_halt);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pc  = '0;
        bus.step_btn = 1'b1; bus.run_sw = 1'b0; bus.burst_req = 1'b0;
        bus.burst_len = '0; bus.brk_en = 1'b0; bus.brk_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 5;
        if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en got %0b exp 0", bus.cpu_en); end
        if (bus.state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted got %0b exp 1", bus.halted); end
        if (bus.brk_hit !== 1'b0) begin n_fail++; $display("FAIL reset_brk_hit got %0b exp 0", bus.brk_hit); end
        if (bus.instr_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_instr_cnt got %0d exp 0", bus.instr_cnt); end
        rst = 1'b1;
        model_reset();
        // Button held through release must not step.
        pulses = 0;
        repeat (3) tick();
        check_int("held_btn_pulses", pulses, 0);
        bus.step_btn = 1'b0;
        tick();
    endtask

    task automatic test_step();
        pulses = 0;
        bus.step_btn = 1'b1;
        tick();
        check_int("step_first_cycle_en", int'(bus.cpu_en), 1);
        repeat (4) tick();
        bus.step_btn = 1'b0;
        repeat (2) tick();
        check_int("step_pulses", pulses, 1);
        check_int("step_instr_cnt", int'(bus.instr_cnt), 1);
        check_int("step_state", int'(bus.state), 0);
    endtask

    task automatic test_run();
        pulses = 0;
        bus.run_sw = 1'b1;
        repeat (18) tick();
        check_int("run_pulses", pulses, 4);
        bus.run_sw = 1'b0;
        pulses = 0;
        repeat (10) tick();
        check_int("run_after_stop_pulses", pulses, 0);
        check_int("run_stop_state", int'(bus.state), 0);
    endtask

    task automatic test_burst();
        logic [31:0] cnt0;
        cnt0 = bus.instr_cnt;
        pulses = 0;
        bus.burst_len = 8'd3; bus.burst_req = 1'b1;
        tick();
        bus.burst_req = 1'b0;
        repeat (20) tick();
        check_int("burst3_pulses", pulses, 3);
        check_int("burst3_state", int'(bus.state), 0);
        check_int("burst3_cnt_delta", int'(bus.instr_cnt - cnt0), 3);
        pulses = 0;
        bus.burst_len = 8'd0; bus.burst_req = 1'b1;
        tick();
        bus.burst_req = 1'b0;
        repeat (10) tick();
        check_int("burst0_pulses", pulses, 0);
        check_int("burst0_state", int'(bus.state), 0);
    endtask

    task automatic test_breakpoint();
        pc = '0;
        bus.brk_en = 1'b1; bus.brk_pc = 32'h0000_000C;
        pulses = 0;
        bus.run_sw = 1'b1;
        repeat (20) tick();
        check_int("brk_pulses", pulses, 3);
        check_int("brk_state", int'(bus.state), 3);
        check_int("brk_hit_set", int'(bus.brk_hit), 1);
        check_int("brk_pc_held", int'(pc), 12);
        pulses = 0;
        bus.step_btn = 1'b1;
        tick();
        check_int("brk_step_en", int'(bus.cpu_en), 1);
        check_int("brk_step_state", int'(bus.state), 0);
        check_int("brk_hit_clear", int'(bus.brk_hit), 0);
        bus.step_btn = 1'b0;
        tick();
        check_int("brk_resume_state", int'(bus.state), 1);
        repeat (8) tick();
        check_int("brk_resume_pulses", pulses, 3);
        bus.run_sw = 1'b0;
        bus.brk_en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bus.run_sw = 1'b1;
        repeat (6) tick();
        #3;
        rst = 1'b0;
        #1;
        n_checks += 5;
        if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL areset_cpu_en got %0b exp 0", bus.cpu_en); end
        if (bus.state !== 2'b00) begin n_fail++; $display("FAIL areset_state got %0d exp 0", bus.state); end
        if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL areset_halted got %0b exp 1", bus.halted); end
        if (bus.brk_hit !== 1'b0) begin n_fail++; $display("FAIL areset_brk_hit got %0b exp 0", bus.brk_hit); end
        if (bus.instr_cnt !== 32'd0) begin n_fail++; $display("FAIL areset_instr_cnt got %0d exp 0", bus.instr_cnt); end
        bus.run_sw = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        pc = '0;
        pulses = 0;
        repeat (12) tick();
        check_int("areset_no_pulses", pulses, 0);
    endtask

    task automatic test_run_beats_burst();
        pulses = 0;
        bus.run_sw = 1'b1; bus.burst_req = 1'b1; bus.burst_len = 8'd5;
        tick();
        bus.burst_req = 1'b0;
        check_int("prio_state", int'(bus.state), 1);
        repeat (39) tick();
        check_int("prio_pulses", pulses, 9);
        check_int("prio_still_run", int'(bus.state), 1);
        bus.run_sw = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.burst_req = 1'b0;
            if ($urandom_range(0, 99) < 3)  bus.run_sw = ~bus.run_sw;
            if ($urandom_range(0, 99) < 20) bus.step_btn = ~bus.step_btn;
            if ($urandom_range(0, 99) < 5) begin
                bus.burst_req = 1'b1;
                bus.burst_len = 8'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 99) < 2) bus.brk_en = ~bus.brk_en;
            if ($urandom_range(0, 99) < 2) bus.brk_pc = 32'(4 * $urandom_range(0, 60));
            tick();
        end
        bus.run_sw = 1'b0; bus.burst_req = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        pulses   = 0;
        model_reset();
        test_reset();
        test_step();
        test_run();
        test_burst();
        test_breakpoint();
        test_async_reset();
        test_run_beats_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_step_ctrl.md
Name: mips_step_ctrl

Overview:
Execution sequencer for the board-level MIPS SoC. It generates a single-cycle clock-enable (cpu_en) that advances the core one instruction at a time. Advance sources are single-step, free-run at a divided rate, or fixed-length bursts, with a PC breakpoint that halts free-run and burst execution. It sits between the debounced board inputs and the SoC, replacing the button-derived CPU clock with a qualified enable on the system clock.

Parameters:
RUN_DIV, 20000, system-clock cycles between cpu_en pulses in RUN/BURST; legal range >=1; 1 means a pulse every cycle.
BURST_W, 8, width of burst_len and the internal remaining-count.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
step_btn  input  1  debounced level; a rising edge requests one step
run_sw  input  1  level; 1 requests free-run
burst_req  input  1  single-cycle pulse; start a burst of burst_len instructions
burst_len  input  BURST_W  burst length, sampled when burst_req is accepted
brk_en  input  1  breakpoint enable
brk_pc  input  32  breakpoint address
pc_current  input  32  current PC from the SoC
cpu_en  output  1  registered single-cycle advance pulse to the SoC
halted  output  1  1 when state is HALT or BREAK
brk_hit  output  1  sticky breakpoint flag
state  output  2  HALT=00, RUN=01, BURST=10, BREAK=11
instr_cnt  output  32  number of cpu_en pulses issued; wraps at 2^32

Behaviour:
- Reset (rst=0, async): state=HALT; cpu_en=0; brk_hit=0; instr_cnt=0; divider=0; remaining=0; btn_q=1. halted=1 (derived from state).
- btn_q=1 at reset prevents a spurious step if the button is held through reset release.
- Step edge detection:
  - btn_q <= step_btn every cycle.
  - step_edge = step_btn & ~btn_q.
  - Latency: cpu_en is high in the cycle after the edge where step_edge was seen.
- cpu_en is registered and never high for two consecutive cycles, except when RUN_DIV=1 in RUN/BURST.
- instr_cnt increments on every cycle in which cpu_en=1.
- Divider:
  - Counts 0..RUN_DIV-1 only in RUN and BURST.
  - The fire condition is divider==RUN_DIV-1; the divider then wraps to 0.
  - It is forced to 0 in HALT and BREAK and on entry to RUN/BURST.
  - The first pulse therefore issues RUN_DIV cycles after entry.
- Breakpoint match: brk_en & (pc_current==brk_pc), evaluated only on a fire condition in RUN/BURST.
- HALT transitions (priority run_sw > burst_req > step_edge):
  - run_sw=1 -> RUN.
  - burst_req=1 and burst_len!=0 -> BURST, remaining<=burst_len.
  - burst_req with burst_len==0 is ignored.
  - step_edge -> issue one cpu_en; stay in HALT. Steps are never breakpoint-checked.
- RUN:
  - run_sw=0 -> HALT in the next cycle; no further pulses, including on that cycle's fire condition.
  - Fire with match -> no pulse, state->BREAK, brk_hit<=1.
  - Fire without match -> pulse.
  - step_btn and burst_req are ignored; btn_q still tracks.
- BURST:
  - Fire with match -> BREAK, brk_hit<=1; remaining is discarded.
  - Fire without match -> pulse and remaining-=1. When remaining goes 1->0, the next state is HALT.
  - run_sw, burst_req and step_btn are ignored until the burst ends. If run_sw=1 when the burst ends, HALT moves to RUN next cycle.
- BREAK:
  - step_edge -> one cpu_en (steps off the breakpoint), brk_hit<=0, state->HALT.
  - If run_sw is still 1, execution resumes via HALT->RUN.
  - All other inputs are ignored.
- pc_current is assumed stable between pulses. The compare uses the PC value present at the fire cycle.
- Changing brk_pc or brk_en takes effect at the next fire evaluation.

Test Plan:
1. Release reset; hold step_btn high 5 cycles -> exactly one cpu_en, the cycle after the first high sample; instr_cnt=1; state=00; halted=1.
2. RUN_DIV=4, run_sw=1 for 18 cycles then 0 -> pulses every 4th cycle starting 4 cycles after entering RUN (4 pulses); no pulses after run_sw falls; state back to 00.
3. burst_len=3 with a burst_req pulse -> exactly 3 pulses spaced RUN_DIV apart, then state=00, instr_cnt=3; repeat with burst_len=0 -> no pulses, state stays 00.
4. brk_en=1, brk_pc=0x0000000C, bench PC model starting at 0 with +4 per cpu_en, run_sw=1 -> 3 pulses (PC 0,4,8); state=11; brk_hit=1; no pulse at PC=0xC; then step_edge -> one pulse, brk_hit=0, HALT then RUN resumes.
5. Assert rst mid-RUN, between pulses -> all outputs take reset values immediately without waiting for a clock edge; no cpu_en after release until a new request.
6. In HALT, run_sw=1 and burst_req=1 (burst_len=5) in the same cycle -> state=RUN; burst ignored; pulses continue indefinitely.
